// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: 4-way round-robin grant controller with a one-cycle bubble between grants.
// Optional hold timeout is built when RR_GRANT_TIMEOUT_EN is defined.
module rr_grant_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       release_i,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic       to_hit;

  // Search upward with wrap, starting just after the last owner.
  always_comb begin
    win   = last_q + 2'd1;
    cand  = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

`ifdef RR_GRANT_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // A same-cycle release wins over the timeout.
  assign to_hit  = (state_q == GRANT) &&
                   (cnt_q == 8'(TIMEOUT - 1)) &&
                   !release_i;
  assign timeout = to_hit;

  always_comb begin
    cnt_d = 8'd0;
    if (state_q == GRANT) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`else
  wire unused_timeout = |TIMEOUT;

  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = win;
          last_d  = win;
        end
      end
      GRANT: begin
        if (release_i || !req[idx_q] || to_hit)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign busy      = (state_q == GRANT);
  assign grant     = busy ? (4'b0001 << idx_q) : 4'b0000;
  assign grant_idx = idx_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: directed and random checks of rr_grant_ctrl
// against a cycle-level behavioural model of the arbitration rules.
module tb_rr_grant_ctrl;

  localparam int TO = 4;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'd0;
  logic       rel = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  bit m_busy;
  int m_owner;
  int m_last;
  int m_hold;

  rr_grant_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .release_i (rel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 3;
    m_hold  = 0;
  endtask

  function automatic bit exp_to(input bit r);
    return TO_EN && m_busy && (m_hold == TO - 1) && !r;
  endfunction

  task automatic model_update(input logic [3:0] r, input bit rl);
    int idx;
    if (!m_busy) begin
      if (r != 4'd0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (r[idx]) begin
            m_owner = idx;
            break;
          end
        end
        m_last = m_owner;
        m_busy = 1'b1;
        m_hold = 0;
      end
    end else begin
      if (rl || !r[m_owner] || exp_to(rl)) m_busy = 1'b0;
      else m_hold++;
    end
  endtask

  task automatic check_outs(input bit rl);
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check("grant", {4'd0, grant}, {4'd0, eg});
    check("busy", {7'd0, busy}, {7'd0, m_busy});
    check("grant_idx", {6'd0, grant_idx}, 8'(m_owner));
    check("timeout", {7'd0, timeout}, {7'd0, exp_to(rl)});
  endtask

  // eg/et < 0 means no extra directed expectation for this cycle.
  task automatic step(input logic [3:0] r, input bit rl,
                      input int eg = -1, input int et = -1);
    req = r;
    rel = rl;
    #1;
    check_outs(rl);
    if (eg >= 0) check("dir_grant", {4'd0, grant}, 8'(eg));
    if (et >= 0) check("dir_timeout", {7'd0, timeout}, 8'(et));
    @(posedge clk);
    model_update(r, rl);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check("rst_grant", {4'd0, grant}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_idx", {6'd0, grant_idx}, 8'h00);
    check("rst_timeout", {7'd0, timeout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting: rotation 0,1,2,3,0 with bubbles.
    step(4'hF, 1'b0, 0);
    step(4'hF, 1'b1, 1);
    step(4'hF, 1'b0, 0);
    step(4'hF, 1'b1, 2);
    step(4'hF, 1'b0, 0);
    step(4'hF, 1'b1, 4);
    step(4'hF, 1'b0, 0);
    step(4'hF, 1'b1, 8);
    step(4'hF, 1'b0, 0);
    step(4'hF, 1'b1, 1);
    step(4'h0, 1'b0, 0);

    // Sole requester 2 holds 5 cycles, bubble, re-granted.
    step(4'h4, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(4'h4, 1'b0, 4);
    step(4'h4, 1'b1, 4);
    step(4'h4, 1'b0, 0);
    step(4'h4, 1'b0, 4);
    step(4'h0, 1'b0, 4);
    step(4'h0, 1'b0, 0);

    // Release ignored in IDLE.
    step(4'h0, 1'b1, 0);

    // Owner 1 drops its request while 0 and 3 wait.
    step(4'h2, 1'b0, 0);
    step(4'h9, 1'b0, 2);
    step(4'h9, 1'b0, 0);
    step(4'h9, 1'b0, 8);
    step(4'h0, 1'b1, 8);
    step(4'h0, 1'b0, 0);

    // Asynchronous reset in the middle of a grant to requester 2.
    step(4'h4, 1'b0, 0);
    step(4'h4, 1'b0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", {4'd0, grant}, 8'h00);
    check("async_rst_busy", {7'd0, busy}, 8'h00);
    check("async_rst_to", {7'd0, timeout}, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h5, 1'b0, 0);
    step(4'h5, 1'b0, 1);
    step(4'h0, 1'b1, 1);
    step(4'h0, 1'b0, 0);

`ifdef RR_GRANT_TIMEOUT_EN
    // Forced revoke after TO cycles of holding.
    step(4'h8, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step(4'h8, 1'b0, 8, 0);
    step(4'h8, 1'b0, 8, 1);
    step(4'h8, 1'b0, 0, 0);
    // Release in the timeout cycle suppresses the pulse.
    for (int i = 0; i < 3; i++) step(4'h8, 1'b0, 8, 0);
    step(4'h8, 1'b1, 8, 0);
    step(4'h0, 1'b0, 0, 0);
`else
    // No timeout: a continuous owner keeps the grant.
    step(4'h8, 1'b0, 0, 0);
    for (int i = 0; i < 300; i++) step(4'h8, 1'b0, 8, 0);
    step(4'h0, 1'b0, 8, 0);
    step(4'h0, 1'b0, 0, 0);
`endif

    // Random traffic, biased towards held requests and rare releases.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      bit rl;
      r  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req;
      rl = ($urandom_range(0, 5) == 0);
      step(r, rl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
